dmem_arbiter: RTL and testbench

- Shared data-memory arbiter for the multi-core CCSS build. It sits directly downstream of each core's AR/DR/data-memory-write path and upstream of the single shared data RAM.
- Each core presents an address (AR), write data (DR), a write strobe and a request. The arbiter grants one core at a time, round-robin, and drives the RAM.
- It returns read data per core and a one-cycle ack. The core's control unit stalls until that ack arrives.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 31 +++
 rtl/dmem_arbiter_rr.sv | 34 +++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the CCSS data-memory arbiter: FSM encoding,
// default geometry and modular index arithmetic.
package ccss_dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;

  // (a + b) mod n for operands already in [0, n); avoids a divider.
  function automatic int wrap_add(input int a, input int b, input int n);
    return ((a + b) >= n) ? (a + b - n) : (a + b);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side request bus and RAM-side port of the data-memory arbiter.
interface dmem_arbiter_if
  import ccss_dmem_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
);
  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        wren;
  logic [NUM_CORES*ADDR_W-1:0] addr;
  logic [NUM_CORES*DATA_W-1:0] wdata;
  logic [NUM_CORES*DATA_W-1:0] rdata;
  logic [NUM_CORES-1:0]        ack;
  logic                        busy;
  logic [NUM_CORES-1:0]        grant;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic                        mem_wren;
  logic [DATA_W-1:0]           mem_rdata;

  modport master (
    output req, wren, addr, wdata, mem_rdata,
    input  rdata, ack, busy, grant, mem_addr, mem_wdata, mem_wren
  );

  modport slave (
    input  req, wren, addr, wdata, mem_rdata,
    output rdata, ack, busy, grant, mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/dmem_arbiter_rr.sv
// Rotating-priority pick: the first requester at or after ptr_i wins.
module rr_arbiter
  import ccss_dmem_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_CORES-1:0] win_oh_o,
  output logic [IDX_W-1:0]     win_idx_o,
  output logic                 valid_o
);

  // Scan from the pointer; the first hit locks the winner.
  always_comb begin
    win_idx_o = '0;
    valid_o   = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!valid_o && req_i[wrap_add(int'(ptr_i), k, NUM_CORES)]) begin
        valid_o   = 1'b1;
        win_idx_o = IDX_W'(wrap_add(int'(ptr_i), k, NUM_CORES));
      end else begin
        valid_o   = valid_o;
      end
    end
    if (valid_o) begin
      win_oh_o = NUM_CORES'(1) << win_idx_o;
    end else begin
      win_oh_o = '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between per-core data-memory ports and one shared
// address-registered RAM; one access per IDLE-ISSUE-WAIT-ACK round.
module dmem_arbiter
  import ccss_dmem_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e                           state_q, state_d;
  logic [NUM_CORES-1:0]             grant_q, grant_d;
  logic [NUM_CORES-1:0]             ack_q, ack_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [IDX_W-1:0]                 ptr_q, ptr_d;
  logic [ADDR_W-1:0]                mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]                mem_wdata_q, mem_wdata_d;
  logic                             mem_wren_q, mem_wren_d;
  logic                             wr_q, wr_d;
  logic                             busy_q, busy_d;
  logic [NUM_CORES-1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic [NUM_CORES-1:0] win_oh_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic                 win_valid_s;

  rr_arbiter #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_rr (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh_s),
    .win_idx_o (win_idx_s),
    .valid_o   (win_valid_s)
  );

  // Next-state and datapath; wr_q remembers the direction after mem_wren drops.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ack_d       = '0;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = mem_wren_q;
    wr_d        = wr_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s) begin
          state_d     = ST_ISSUE;
          grant_d     = win_oh_s;
          idx_d       = win_idx_s;
          mem_addr_d  = bus.addr[win_idx_s*ADDR_W +: ADDR_W];
          mem_wdata_d = bus.wdata[win_idx_s*DATA_W +: DATA_W];
          mem_wren_d  = bus.wren[win_idx_s];
          wr_d        = bus.wren[win_idx_s];
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        mem_wren_d = 1'b0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_ACK;
        ack_d   = grant_q;
        if (wr_q) begin
          rdata_d[idx_q] = rdata_q[idx_q];
        end else begin
          rdata_d[idx_q] = bus.mem_rdata;
        end
      end
      ST_ACK: begin
        grant_d = '0;
        ptr_d   = IDX_W'(wrap_add(int'(idx_q), 1, NUM_CORES));
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        mem_wren_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ack_q       <= '0;
      idx_q       <= '0;
      ptr_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.grant     = grant_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: a transaction-level model of the arbiter plus a RAM,
// reactive core drivers and directed scenarios with literal expectations.
module tb_dmem_arbiter;
  import ccss_dmem_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-core operation tables; the driver issues want-done requests.
  int              want [N];
  int              done [N];
  logic            op_wr [N];
  logic [AW-1:0]   op_addr [N];
  logic [AW-1:0]   alt_addr [N];
  logic [DW-1:0]   op_wdata [N];
  logic            drop_early [N];
  logic            mutate [N];

  // Address-registered RAM.
  logic [DW-1:0] ram [int];
  always @(posedge clk) begin
    logic [DW-1:0] rd;
    rd = ram.exists(int'(bus.mem_addr)) ? ram[int'(bus.mem_addr)] : '0;
    if (bus.mem_wren) ram[int'(bus.mem_addr)] = bus.mem_wdata;
    bus.mem_rdata <= rd;
  end

  // Core drivers: hold req until ack, optional early drop / operand change.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      bus.req   = '0;
      bus.wren  = '0;
      bus.addr  = '0;
      bus.wdata = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i]) begin
          bus.req[i] = 1'b0;
          done[i] = done[i] + 1;
        end else if (bus.grant[i]) begin
          if (drop_early[i]) bus.req[i] = 1'b0;
          if (mutate[i]) bus.addr[i*AW +: AW] = alt_addr[i];
        end else if (!bus.req[i] && done[i] < want[i]) begin
          bus.req[i]              = 1'b1;
          bus.wren[i]             = op_wr[i];
          bus.addr[i*AW +: AW]    = op_addr[i];
          bus.wdata[i*DW +: DW]   = op_wdata[i];
        end
      end
    end
  end

  // Reference model: each granted access occupies a 4-cycle window.
  logic          m_active = 1'b0;
  int            m_age = 0;
  int            m_win = 0;
  int            m_ptr = 0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata [N];
  logic [DW-1:0] mdl_mem [int];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_ptr    = 0;
      for (int i = 0; i < N; i++) m_rdata[i] = '0;
    end else if (m_active) begin
      m_age = m_age + 1;
      if (m_age == 1 && m_wr) mdl_mem[int'(m_addr)] = m_wdata;
      if (m_age == 2 && !m_wr)
        m_rdata[m_win] = mdl_mem.exists(int'(m_addr)) ? mdl_mem[int'(m_addr)] : '0;
      if (m_age == 3) begin
        m_active = 1'b0;
        m_ptr    = (m_win + 1) % N;
      end
    end else if (bus.req != '0) begin
      for (int k = 0; k < N; k++) begin
        if (!m_active && bus.req[(m_ptr + k) % N]) begin
          m_win    = (m_ptr + k) % N;
          m_active = 1'b1;
        end
      end
      m_age   = 0;
      m_wr    = bus.wren[m_win];
      m_addr  = bus.addr[m_win*AW +: AW];
      m_wdata = bus.wdata[m_win*DW +: DW];
    end
  end

  // Logs of grants/acks and count of mem_wren cycles.
  int   ack_idx [$];
  int   ack_cyc [$];
  int   gnt_cyc [$];
  int   wren_cnt = 0;
  logic [N-1:0] prev_grant = '0;

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    logic [N-1:0] e_grant, e_ack;
    if (!rst) begin
      e_grant = m_active ? (N'(1) << m_win) : '0;
      e_ack   = (m_active && m_age == 2) ? (N'(1) << m_win) : '0;
      chk("grant", 64'(bus.grant), 64'(e_grant));
      chk("ack", 64'(bus.ack), 64'(e_ack));
      chk("busy", 64'(bus.busy), 64'(m_active));
      chk("mem_wren", 64'(bus.mem_wren), 64'(m_active && m_age == 0 && m_wr));
      for (int i = 0; i < N; i++)
        chk($sformatf("rdata%0d", i), 64'(bus.rdata[i*DW +: DW]), 64'(m_rdata[i]));
      if (m_active) begin
        chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
      end
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i]) begin
          ack_idx.push_back(i);
          ack_cyc.push_back(cyc);
        end
      end
      if (bus.grant != '0 && prev_grant == '0) gnt_cyc.push_back(cyc);
      if (bus.mem_wren) wren_cnt = wren_cnt + 1;
      prev_grant = bus.grant;
    end else begin
      prev_grant = '0;
    end
  end

  task automatic set_op(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_wr[i]    = wr;
    op_addr[i]  = a;
    op_wdata[i] = d;
    want[i]     = want[i] + 1;
  endtask

  task automatic run(input string name, input int bound);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < bound && !ok; c++) begin
      @(negedge clk);
      ok = !bus.busy;
      for (int i = 0; i < N; i++) if (done[i] != want[i]) ok = 1'b0;
    end
    if (!ok) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL %s: timeout after %0d cycles", name, bound);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < N; i++) want[i] = done[i];
    @(posedge clk);
    #2 rst = 1'b0;
    ack_idx.delete();
    ack_cyc.delete();
    gnt_cyc.delete();
  endtask

  task automatic wait_grant(input int i, input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound && !ok; c++) begin
      @(negedge clk);
      ok = bus.grant[i];
    end
    if (!ok) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL wait_grant%0d: timeout", i);
    end
  endtask

  initial begin
    bit got;
    int exp_seq [4];
    for (int i = 0; i < N; i++) begin
      want[i] = 0; done[i] = 0; op_wr[i] = 1'b0; op_addr[i] = '0; alt_addr[i] = '0;
      op_wdata[i] = '0; drop_early[i] = 1'b0; mutate[i] = 1'b0;
      ram[32'h20 + i]     = DW'(16'h00A0 + i);
      mdl_mem[32'h20 + i] = DW'(16'h00A0 + i);
    end
    ram[32'h40] = 16'h4040; mdl_mem[32'h40] = 16'h4040;
    ram[32'h41] = 16'h4141; mdl_mem[32'h41] = 16'h4141;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_grant", 64'(bus.grant), 64'd0);
    chk("rst_ack", 64'(bus.ack), 64'd0);
    chk("rst_mem_wren", 64'(bus.mem_wren), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    #1 rst = 1'b0;

    // Write then read back, core 0.
    wren_cnt = 0;
    set_op(0, 1'b1, 16'h0010, 16'hBEEF);
    run("wr0", 40);
    chk("wr0_wren_cycles", 64'(wren_cnt), 64'd1);
    chk("wr0_ack_latency", 64'(ack_cyc[$] - gnt_cyc[$]), 64'd2);
    chk("wr0_ack_core", 64'(ack_idx[$]), 64'd0);
    set_op(0, 1'b0, 16'h0010, 16'h0000);
    run("rd0", 40);
    chk("rd0_rdata", 64'(bus.rdata[0*DW +: DW]), 64'h0000_0000_0000_BEEF);

    // Contention: all four cores at once, pointer reset to 0.
    pulse_reset();
    for (int i = 0; i < N; i++) set_op(i, 1'b0, AW'(16'h0020 + i), 16'h0000);
    run("contend", 80);
    exp_seq = '{0, 1, 2, 3};
    chk("contend_n_acks", 64'(ack_idx.size()), 64'd4);
    for (int k = 0; k < 4 && k < ack_idx.size(); k++)
      chk($sformatf("contend_order%0d", k), 64'(ack_idx[k]), 64'(exp_seq[k]));
    for (int k = 1; k < 4 && k < ack_cyc.size(); k++)
      chk($sformatf("contend_spacing%0d", k), 64'(ack_cyc[k] - ack_cyc[k-1]), 64'd4);
    for (int i = 0; i < N; i++)
      chk($sformatf("contend_rdata%0d", i), 64'(bus.rdata[i*DW +: DW]), 64'(16'h00A0 + i));

    // Fairness: cores 1 and 3 both keep requesting.
    pulse_reset();
    set_op(1, 1'b0, 16'h0021, 16'h0000); want[1] = want[1] + 1;
    set_op(3, 1'b0, 16'h0023, 16'h0000); want[3] = want[3] + 1;
    run("fair", 100);
    exp_seq = '{1, 3, 1, 3};
    chk("fair_n_acks", 64'(ack_idx.size()), 64'd4);
    for (int k = 0; k < 4 && k < ack_idx.size(); k++)
      chk($sformatf("fair_order%0d", k), 64'(ack_idx[k]), 64'(exp_seq[k]));

    // Dropped req: the write still completes and acks.
    drop_early[2] = 1'b1;
    set_op(2, 1'b1, 16'h0030, 16'h1234);
    run("drop", 40);
    drop_early[2] = 1'b0;
    chk("drop_ack_core", 64'(ack_idx[$]), 64'd2);
    set_op(2, 1'b0, 16'h0030, 16'h0000);
    run("drop_rd", 40);
    chk("drop_rdata", 64'(bus.rdata[2*DW +: DW]), 64'h1234);

    // Async reset while core 1's read is in WAIT.
    set_op(1, 1'b0, 16'h0022, 16'h0000);
    wait_grant(1, 40, got);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("amid_busy", 64'(bus.busy), 64'd0);
    chk("amid_ack", 64'(bus.ack), 64'd0);
    chk("amid_mem_wren", 64'(bus.mem_wren), 64'd0);
    chk("amid_grant", 64'(bus.grant), 64'd0);
    chk("amid_rdata", 64'(bus.rdata), 64'd0);
    for (int i = 0; i < N; i++) want[i] = done[i];
    @(posedge clk);
    #2 rst = 1'b0;
    ack_idx.delete();
    set_op(3, 1'b0, 16'h0023, 16'h0000);
    set_op(0, 1'b0, 16'h0020, 16'h0000);
    run("post_rst", 60);
    chk("post_rst_n_acks", 64'(ack_idx.size()), 64'd2);
    if (ack_idx.size() == 2) begin
      chk("post_rst_first", 64'(ack_idx[0]), 64'd0);
      chk("post_rst_second", 64'(ack_idx[1]), 64'd3);
    end

    // Operand stability: addr changes after the grant edge are ignored.
    mutate[0] = 1'b1;
    alt_addr[0] = 16'h0041;
    set_op(0, 1'b0, 16'h0040, 16'h0000);
    wait_grant(0, 40, got);
    chk("stab_addr_issue", 64'(bus.mem_addr), 64'h0040);
    @(negedge clk);
    chk("stab_addr_wait", 64'(bus.mem_addr), 64'h0040);
    run("stab", 40);
    mutate[0] = 1'b0;
    chk("stab_rdata", 64'(bus.rdata[0*DW +: DW]), 64'h4040);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
